// File: rtl/frame_former_scheduler.sv
// ----------------------------------------------------------------------------
// frame_former_scheduler
//
// Round-robin scheduler sharing one downstream Ethernet framer among
// NUM_SOURCES frame-former buffers. A source is granted only when it already
// holds a full frame, so a granted frame never stalls on its buffer. The
// granted buffer is popped through its FramerReady strobe (src_pop) and its
// words are re-emitted as an AXI-Stream frame of FRAME_BEATS words with tlast.
//
// Ports
//   ACLK, ARESETN   : clock (rising edge), asynchronous active-low reset
//   src_count       : per-buffer occupancy, CW bits per source (slice i = src i)
//   src_empty       : per-buffer empty flag
//   src_data        : per-buffer head word, DATA_WIDTH bits per source
//   src_enable      : per-source scheduling enable
//   src_pop         : one-hot pop strobe to the granted buffer
//   M_AXIS_*        : AXI-Stream master toward the framer (tkeep fixed 8'hFF)
//   grant_id        : source currently or most recently granted
//   busy            : high while a frame is being loaded
//   frame_count     : frames fully loaded, wraps at 2^16
//   underflow_err   : sticky, set when a pop hits an empty buffer
// ----------------------------------------------------------------------------
module frame_former_scheduler #(
    parameter int unsigned NUM_SOURCES        = 4,
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned MAX_INTERNAL_SPACE = 64,
    parameter int unsigned FRAME_BEATS        = 8,
    localparam int unsigned CW = $clog2(MAX_INTERNAL_SPACE) + 1,
    localparam int unsigned IW = $clog2(NUM_SOURCES)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_SOURCES*CW-1:0]     src_count,
    input  logic [NUM_SOURCES-1:0]        src_empty,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]        src_enable,
    output logic [NUM_SOURCES-1:0]        src_pop,
    output logic [DATA_WIDTH-1:0]         M_AXIS_tdata,
    output logic [7:0]                    M_AXIS_tkeep,
    output logic                          M_AXIS_tvalid,
    output logic                          M_AXIS_tlast,
    input  logic                          M_AXIS_tready,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic                          underflow_err
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                r_state;
    logic [IW-1:0]         r_grant;
    logic [IW-1:0]         r_last_grant;
    logic [CW-1:0]         r_beat;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_busy;
    logic [15:0]           r_frame_count;
    logic                  r_underflow;

    logic [DATA_WIDTH-1:0]  w_src_data [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] w_eligible;
    logic                   w_found;
    logic [IW-1:0]          w_next;
    logic                   w_ld;
    logic                   w_last_beat;
    logic [NUM_SOURCES-1:0] w_pop;
    logic                   w_underflow_hit;

    // Unpack the flat per-source buses and decide eligibility.
    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        assign w_src_data[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_eligible[g] = src_enable[g] &&
                               (src_count[g*CW +: CW] >= CW'(FRAME_BEATS));
    end

    // Round-robin search: first eligible source after the last grant.
    always_comb begin
        logic [IW-1:0] idx;
        w_found = 1'b0;
        w_next  = '0;
        idx     = '0;
        for (int k = 1; k <= int'(NUM_SOURCES); k++) begin
            idx = IW'((int'(r_last_grant) + k) % int'(NUM_SOURCES));
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_next  = idx;
            end
        end
    end

    // The output register can take a new word when empty or being drained.
    assign w_ld        = !r_tvalid || M_AXIS_tready;
    assign w_last_beat = (r_beat == CW'(FRAME_BEATS - 1));

    // Pop strobe is combinational so the buffer advances on the same edge
    // that captures its head word.
    always_comb begin
        w_pop = '0;
        if (r_state == StSend && w_ld) begin
            w_pop[r_grant] = 1'b1;
        end
    end

    assign w_underflow_hit = |(w_pop & src_empty);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_last_grant  <= IW'(NUM_SOURCES - 1);
            r_beat        <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_underflow_hit) begin
                r_underflow <= 1'b1;
            end

            // Drain; overridden below if a new word loads on this edge.
            if (r_tvalid && M_AXIS_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    // Arbitration may overlap a last word still stalled at
                    // the output; the first load then waits on w_ld.
                    if (w_found) begin
                        r_grant      <= w_next;
                        r_last_grant <= w_next;
                        r_beat       <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= StSend;
                    end
                end
                StSend: begin
                    if (w_ld) begin
                        r_tdata  <= w_src_data[r_grant];
                        r_tvalid <= 1'b1;
                        r_tlast  <= w_last_beat;
                        r_beat   <= r_beat + CW'(1);
                        if (w_last_beat) begin
                            r_state       <= StIdle;
                            r_busy        <= 1'b0;
                            r_frame_count <= r_frame_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign src_pop       = w_pop;
    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tlast  = r_tlast;
    assign M_AXIS_tkeep  = r_tvalid ? 8'hFF : 8'h00;
    assign grant_id      = r_grant;
    assign busy          = r_busy;
    assign frame_count   = r_frame_count;
    assign underflow_err = r_underflow;

endmodule

// File: doc/frame_former_scheduler.md
# frame_former_scheduler

Round-robin scheduler that shares one downstream framer among `NUM_SOURCES` frame-former subordinate buffers. It watches each buffer's fill count and grants the framer to one eligible buffer for exactly one frame of `FRAME_BEATS` words. It pops those words through the buffer's `FramerReady` pop strobe and re-emits them as an AXI-Stream frame with `tlast`. It sits between the subordinate buffers and the Ethernet framer.

## Interface
- `NUM_SOURCES`, 4: number of subordinate buffers; must be ≥2.
- `DATA_WIDTH`, 64: word width; matches the buffer `OUTPUT_WIDTH`.
- `MAX_INTERNAL_SPACE`, 64: buffer depth. Count width is `CW = $clog2(MAX_INTERNAL_SPACE)+1`.
- `FRAME_BEATS`, 8: words per frame; 1 ≤ `FRAME_BEATS` ≤ `MAX_INTERNAL_SPACE-1`.
- `ACLK` in 1: clock, rising edge.
- `ARESETN` in 1: reset, asynchronous assert, active-low.
- `src_count` in `NUM_SOURCES*CW`: per-buffer occupancy (buffer tail). Slice i belongs to source i.
- `src_empty` in `NUM_SOURCES`: per-buffer empty flag.
- `src_data` in `NUM_SOURCES*DATA_WIDTH`: per-buffer head word (buffer `tempOut`).
- `src_enable` in `NUM_SOURCES`: per-source scheduling enable.
- `src_pop` out `NUM_SOURCES`: one-hot pop strobe, wired to each buffer's `FramerReady`.
- `M_AXIS_tdata` out `DATA_WIDTH`: frame word.
- `M_AXIS_tkeep` out 8: constant `8'hFF` while `tvalid`, 0 otherwise.
- `M_AXIS_tvalid` out 1: word valid.
- `M_AXIS_tlast` out 1: last word of the frame.
- `M_AXIS_tready` in 1: framer ready.
- `grant_id` out `$clog2(NUM_SOURCES)`: source currently or most recently granted.
- `busy` out 1: high while in SEND.
- `frame_count` out 16: frames fully loaded; wraps at 2^16.
- `underflow_err` out 1: sticky; set when a pop hits an empty source.

## Operation
- Eligibility: source i is eligible when `src_enable[i]` is high and `src_count[i] ≥ FRAME_BEATS`. A granted frame therefore never waits on its buffer.
- FSM has two states, IDLE and SEND.
- IDLE:
  - Round-robin search starts at `last_grant+1` (mod `NUM_SOURCES`). The first eligible source is registered into `grant_id` and `last_grant`, `beat` is cleared to 0, and the FSM moves to SEND.
  - With no eligible source the FSM stays in IDLE.
- SEND:
  - The load condition is `ld = !M_AXIS_tvalid || M_AXIS_tready`.
  - On `ld`, `src_pop[grant_id]` is asserted combinationally in that cycle. On the edge, the output register captures `src_data[grant_id]`, `tvalid` is set to 1, `tlast` is set to `(beat == FRAME_BEATS-1)`, and `beat` increments.
  - When the last beat loads, the FSM returns to IDLE and `frame_count` increments.
- Output register: when `tvalid && tready` and no new load occurs, `tvalid` and `tlast` clear. `tdata` holds its value while `tvalid && !tready`.
- `src_pop` is zero outside SEND and when `ld` is low. It is never multi-hot.
- `underflow_err` sets when `src_pop[i]` is asserted while `src_empty[i]` is high. It clears only on reset.
- Changes to `src_enable` or `src_count` during SEND are ignored; the current frame always completes.
- Arbitration may occur in IDLE while the last word of the previous frame is still stalled in the output register. The next frame's first load waits on `ld`.

## Timing
- Reset values: `src_pop` 0, `M_AXIS_tvalid` 0, `M_AXIS_tlast` 0, `M_AXIS_tdata` 0, `M_AXIS_tkeep` 0, `grant_id` 0, `busy` 0, `frame_count` 0, `underflow_err` 0, FSM in IDLE, `last_grant = NUM_SOURCES-1` (so source 0 has first priority).
- Reset takes effect immediately and asynchronously, including mid-frame. Outputs drop without waiting for a clock edge, and no partial-frame recovery is attempted.
- Latency, assuming `tready` held high:
  - Eligibility is seen at edge N; SEND is entered at N.
  - The first pop occurs in cycle N..N+1, and `tvalid` rises after edge N+1.
  - Throughput is one word per cycle, so a frame occupies `FRAME_BEATS` consecutive cycles.
  - One IDLE cycle separates back-to-back frames.
- `tvalid`, `tdata`, `tlast` and `tkeep` are stable while `tvalid && !tready`, per AXI-Stream rules.
- `busy` equals (state == SEND), registered.

## Test plan
- Single source: source 0 count=8, `FRAME_BEATS`=8, `tready`=1. Expect 8 pops on consecutive cycles, words D0..D7 out in order, `tlast` only on D7, `frame_count`=1, FSM back in IDLE.
- Round-robin: all 4 sources hold count ≥16 with enable high. Expect grants 0,1,2,3,0,1,… with one IDLE cycle between frames and `tlast` on every 8th word.
- Backpressure: toggle `tready` 1,0,0,1 during a frame. Expect no pop while `tvalid && !tready`, held data stable, and all 8 words delivered exactly once.
- Ineligible and disabled sources: source 1 count=7, source 2 enable=0 with count=20, source 3 count=8. Expect only source 3 granted; `src_pop[1]` and `src_pop[2]` never asserted.
- Reset mid-frame: assert `ARESETN`=0 after beat 3. Expect `tvalid`, `src_pop` and `busy` to drop asynchronously. After release, expect source 0 granted first.
- Underflow: force `src_empty[0]`=1 during a granted pop. Expect `underflow_err`=1, held until reset.
